// File: rtl/pong_pkg.sv
// Shared matrix geometry and scan-phase types for the pong renderer
// and the LED matrix scanner.
package pong_pkg;

    localparam int MATRIX_ROWS = 4;
    localparam int MATRIX_COLS = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int COL_W = idx_w(MATRIX_COLS);

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_e;

endpackage

// File: rtl/led_matrix_scanner_scan_timer.sv
// Dwell and column counters for the matrix scan; flags the blanking
// phase, the head of each frame and the frame-wrap (swap) edge.
module scan_timer
    import pong_pkg::*;
#(
    parameter int COLS  = MATRIX_COLS,
    parameter int DWELL = 1024,
    parameter int BLANK = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    output logic [$clog2(COLS)-1:0]  col,
    output phase_e                   phase,
    output logic                     frame_head,
    output logic                     swap
);

    localparam int CW = idx_w(DWELL);
    localparam int KW = $clog2(COLS);
    localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);
    localparam logic [KW-1:0] LAST_COL = KW'(COLS - 1);

    logic [CW-1:0] cnt;
    logic          last_cnt;
    logic          last_col;

    assign last_cnt   = (cnt == LAST_CNT);
    assign last_col   = (col == LAST_COL);
    assign swap       = enable && last_cnt && last_col;
    assign frame_head = (cnt == '0) && (col == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            col <= '0;
        end else if (enable) begin
            if (last_cnt) begin
                cnt <= '0;
                col <= last_col ? '0 : col + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // With no blanking the column is driven for the whole dwell.
    if (BLANK == 0) begin : g_noblank
        assign phase = PH_DRIVE;
    end else begin : g_blank
        localparam logic [CW-1:0] BLANK_C = CW'(BLANK);
        assign phase = (cnt < BLANK_C) ? PH_BLANK : PH_DRIVE;
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// Column-multiplexed LED matrix driver with a double-buffered frame,
// per-column blanking and fully registered pin outputs.
module led_matrix_scanner
    import pong_pkg::*;
#(
    parameter int ROWS           = MATRIX_ROWS,
    parameter int COLS           = MATRIX_COLS,
    parameter int DWELL          = 1024,
    parameter int BLANK          = 16,
    parameter bit COL_ACTIVE_LOW = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ROWS*COLS-1:0]     frame_in,
    input  logic                     frame_load,
    input  logic                     enable,
    output logic [COLS-1:0]          col_sel,
    output logic [ROWS-1:0]          row_data,
    output logic [$clog2(COLS)-1:0]  col_idx,
    output logic                     frame_start,
    output logic                     load_pending
);

    localparam int KW = $clog2(COLS);
    localparam logic [COLS-1:0] COL_OFF = {COLS{COL_ACTIVE_LOW}};

    logic [ROWS*COLS-1:0]       active;
    logic [ROWS*COLS-1:0]       shadow;
    logic [ROWS-1:0][COLS-1:0]  act2;
    logic [ROWS-1:0]            pix;
    logic [COLS-1:0]            onehot;
    logic [KW-1:0]              col;
    phase_e                     phase;
    logic                       frame_head;
    logic                       swap;
    logic                       drive;

    scan_timer #(
        .COLS  (COLS),
        .DWELL (DWELL),
        .BLANK (BLANK)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .col        (col),
        .phase      (phase),
        .frame_head (frame_head),
        .swap       (swap)
    );

    // A load on the swap edge refills the shadow, so the flag stays set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active       <= '0;
            shadow       <= '0;
            load_pending <= 1'b0;
        end else begin
            if (swap && load_pending) begin
                active <= shadow;
            end
            if (frame_load) begin
                shadow       <= frame_in;
                load_pending <= 1'b1;
            end else if (swap) begin
                load_pending <= 1'b0;
            end
        end
    end

    assign act2   = active;
    assign onehot = COLS'(1) << col;
    assign drive  = enable && (phase == PH_DRIVE);

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign pix[ROWS-1-r] = act2[r][col];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_sel     <= COL_OFF;
            row_data    <= '0;
            col_idx     <= '0;
            frame_start <= 1'b0;
        end else begin
            col_sel     <= COL_OFF ^ (drive ? onehot : '0);
            row_data    <= drive ? pix : '0;
            col_idx     <= col;
            frame_start <= enable && frame_head;
        end
    end

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
Parametrised column-multiplexed LED matrix driver. Holds a ROWS x COLS pixel frame in a double buffer and steps through the columns at a programmable dwell rate. Each column has a blanking interval so that ghosting does not occur. Sits between the game renderer, which writes whole frames, and the physical matrix pins. Replaces the fixed 4x4 externally-counted column selector.

Parameters:
ROWS, 4, number of matrix rows (row_data width), >=1
COLS, 4, number of matrix columns (col_sel width), >=2
DWELL, 1024, clk cycles per column including blanking, >=2
BLANK, 16, leading cycles of each column with outputs off, 0 <= BLANK < DWELL
COL_ACTIVE_LOW, 0, 1 inverts col_sel polarity at the pins

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
frame_in  in  ROWS*COLS  pixel (r,c) at bit r*COLS+c, row-major
frame_load  in  1  single-cycle strobe: capture frame_in into shadow buffer
enable  in  1  0 freezes scanning; outputs blanked
col_sel  out  COLS  one-hot column drive (inverted if COL_ACTIVE_LOW)
row_data  out  ROWS  row_data[ROWS-1-r] = active pixel (r, col_idx)
col_idx  out  clog2(COLS)  current column index
frame_start  out  1  one-cycle pulse on first cycle of column 0
load_pending  out  1  shadow holds a frame not yet swapped to active

Behaviour:
- Reset (async assert, sync release): active buffer, shadow buffer, col_idx, and dwell counter all 0; load_pending=0; frame_start=0; row_data=0; col_sel all-off (0, or all-1 if COL_ACTIVE_LOW).
- Dwell counter runs 0..DWELL-1 while enable=1. At DWELL-1 it wraps to 0, and col_idx advances; col_idx wraps COLS-1 -> 0.
- Phases per column. BLANK: count < BLANK, col_sel off, row_data=0. DRIVE: count >= BLANK, col_sel bit col_idx on, row_data = column pixels.
- All outputs are registered. They reflect the state of the current cycle's counters with 1 cycle latency, with no combinational path from inputs to outputs.
- frame_load=1: shadow <= frame_in and load_pending <= 1 on the next edge. Repeated loads before a swap overwrite the shadow; the last one wins.
- Swap: on the edge where col_idx wraps COLS-1 -> 0, if load_pending=1 then active <= shadow and load_pending <= 0. The active buffer never changes mid-frame.
- Load on the swap edge: frame_load coinciding with the swap edge writes the shadow with the new frame and load_pending stays 1. The old shadow content is swapped to active.
- frame_start: pulses for one cycle when count=0 and col_idx=0, including the first cycle after reset release with enable=1.
- enable=0: counters hold, outputs are forced off/0 on the next edge, and loads are still accepted. When enable returns to 1, scanning resumes from the held count.
- BLANK=0: no blanking; the column is driven for the full DWELL.

Decomposition:
- Shared package pong_pkg holds the clog2-derived width constant for col_idx and the matrix default dimensions (4x4) used by the renderer and the scanner.
- One natural sub-module, scan_timer: dwell counter plus column counter, emitting col_idx, phase, and the wrap/swap strobe. The buffers and output registers stay in the top.

Test Plan:
All scenarios use ROWS=4, COLS=4, DWELL=4, BLANK=1.
1. Reset value: assert rst mid-scan -> col_sel=0, row_data=0, col_idx=0, and load_pending=0 immediately, without waiting for clk.
2. Load 16'h8421 (diagonal) then run one frame -> load_pending=1 until the first wrap. In the next frame, column c drives row_data with a single bit set, row c (row_data[3-c]=1).
3. Timing check -> each column shows 1 cycle off then 3 cycles on, and col_sel steps 0001,0010,0100,1000. frame_start occurs every 16 cycles.
4. Mid-frame load at col_idx=2 -> row_data is unchanged until after col 3. Two loads in the same frame -> only the second appears.
5. frame_load coincident with the swap edge -> the old shadow appears in this frame, the new one in the next, and load_pending=1 after the swap.
6. Drop enable for 5 cycles at count=2 -> outputs are 0 during that time, and on resume the column completes its remaining cycles. With COL_ACTIVE_LOW=1, the off state is col_sel=4'b1111.
